sic_exec_multi: RTL and testbench
=================================

Name: sic_exec_multi

Overview:
- Multi-context successor to the single-packet simple SIC executor. Holds up to NUM_CTX in-flight simple packets (LUI, LINK, JR, NOP) in a circular buffer and resolves JR operands out of order.
- Commits strictly in allocation order, one per cycle, gated by each packet's dependency ECR. Sits in a SIC slot between the packet dispatcher, RF arbiter, ECR file and the PC redirect mux.

Parameters:
- SIC_ID, 0, slot index used in debug/stat output
- NUM_CTX, 4, buffer depth (power of 2, >=2)
- NUM_PHY_REGS, 64, physical register count; PHY_W = $clog2(NUM_PHY_REGS)
- ID_WIDTH, 8, issue-id width
- NUM_ECR, 2, ECR count; ECR_W = $clog2(NUM_ECR)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_instr  out  1  buffer has a free slot
- pkt_valid  in  1  packet present; accepted iff pkt_valid && req_instr
- pkt_kind  in  2  sic_simple_kind_e: NOP=0, LUI=1, LINK=2, JR=3
- pkt_pc  in  32  packet PC
- pkt_imm16  in  16  LUI immediate
- pkt_issue_id  in  ID_WIDTH  issue id
- pkt_rs  in  PHY_W  JR source physical register
- pkt_dst  in  PHY_W  LUI/LINK destination
- pkt_ecr_id  in  ECR_W  dependency ECR
- rd_req  out  1  read request
- rd_addr  out  PHY_W  read address
- rd_valid  in  1  same-cycle grant with data
- rd_data  in  32  read data
- ecr_status  in  2*NUM_ECR  all ECR states (2 bits each): 00 Busy, 01 Correct, 10 Incorrect
- wb_valid  out  1  RF commit strobe
- wb_addr  out  PHY_W  commit address
- wb_data  out  32  commit data
- pc_redirect_valid  out  1  JR redirect strobe, registered
- pc_redirect_pc  out  32  redirect target
- pc_redirect_issue_id  out  ID_WIDTH  redirect issue id

Behaviour:
- Reset (async, rst_n=0): head, tail and count = 0. All entries have valid=0. Registered outputs are 0: pc_redirect_*, plus stat counters when enabled.
- Reset mid-operation drops every entry; no commit or redirect is emitted.
- Entry fields: valid, dead, opnd_ok, kind, pc, imm/wdata, issue_id, rs, dst, ecr_id.
- Allocation: req_instr = (count != NUM_CTX).
  - On accept, write the entry at tail and advance tail, wrapping mod NUM_CTX.
  - opnd_ok = (kind != JR).
  - wdata is precomputed: LUI gives {imm16,16'h0}; LINK gives pc+4, with 32-bit wraparound (pc=FFFF_FFFC gives 0).
- Operand read: rd_req is asserted for the oldest valid, !dead, !opnd_ok entry (scan from head), with rd_addr = its rs. On rd_valid, latch rd_data as the target and set opnd_ok next edge. Back-to-back requests are allowed.
- Abort: any valid entry whose ECR reads 10 sets dead next edge. This applies to all such entries in parallel; rd_req skips dead entries.
- Commit, evaluated on the head entry only:
  - If dead, or its ECR reads 10: retire silently, with no outputs.
  - Else if opnd_ok and ECR = 01: retire.
    - LUI/LINK: wb_valid=1 combinationally, wb_addr=dst, wb_data=wdata.
    - JR: the redirect registers load next edge, giving a 1-cycle redirect pulse.
    - NOP: retire only.
  - Else (ECR 00 or operand pending): stall. Entries behind the head never commit.
- Throughput: at most one retire per cycle. wb_valid is combinational from head state. Redirect latency = 1 cycle after retire.
- Simultaneous accept and retire in the same cycle: count is unchanged; pointers are independent. Full with retire: req_instr stays low that cycle; the next cycle it is high.
- Accept into an empty buffer: earliest commit is the next cycle (no same-cycle bypass).
- pc_redirect_valid defaults to 0 every cycle unless loaded.

Optional Feature:
- SIC_EXEC_STATS_EN defined:
  - 32-bit saturating registers stat_commits, stat_aborts and stat_stall_cycles. A stall cycle is head valid and not retiring.
  - Exposed as extra output ports.
  - Simulation $display of totals at $finish, tagged with SIC_ID.
- Undefined: no counters and no ports. Behaviour is otherwise identical.

Decomposition:
- sic_pkg gets sic_simple_kind_e, the ECR encodings (ECR_BUSY, ECR_OK, ECR_BAD) and the sic_ctx_entry_t struct template.
- One sub-module: sic_oldest_pick, a parametrised rotate-from-head priority picker. It is used for rd_req selection.

Test Plan:
- LUI imm16=1234, dst=5, ECR0=00 for 3 cycles then 01 -> no wb during Busy; wb_valid one cycle with addr 5, data 0x12340000.
- LINK pc=0x0040_0010 followed by JR rs=7 (rd_data=0x0040_0100, ECR=01) -> wb data 0x0040_0014, then pc_redirect_valid pulse with pc 0x0040_0100 and the JR issue id, in order.
- Fill NUM_CTX=4 with head ECR Busy -> req_instr=0 after 4 accepts. Release ECR -> retire and accept in the same cycle; tail wraps to 0 correctly.
- Three entries on ECR1 go to 10 while the head is Busy on ECR0 -> entries marked dead. After the head commits, three silent retires follow with no wb or redirect.
- JR at head with rd_valid held 0 for 5 cycles, and a younger LUI with ECR ok -> the LUI does not commit before the JR. Then rd_valid=1 -> JR redirect, then the LUI wb.
- Assert rst_n low with 3 entries pending -> outputs 0 immediately, req_instr=1 after release, and no stale commit.

Source files
------------

// File: rtl/sic_pkg.sv
// Shared types for the simple SIC executors.
// Packet kinds, ECR state codes and the context entry layout.
package sic_pkg;

   typedef enum logic [1:0] {
      SIC_NOP  = 2'd0,
      SIC_LUI  = 2'd1,
      SIC_LINK = 2'd2,
      SIC_JR   = 2'd3
   } sic_simple_kind_e;

   localparam logic [1:0] ECR_BUSY = 2'b00;
   localparam logic [1:0] ECR_OK   = 2'b01;
   localparam logic [1:0] ECR_BAD  = 2'b10;

   // Width-independent part of a context entry; the id/register
   // fields depend on top-level parameters and live beside it.
   typedef struct packed {
      logic             valid;
      logic             dead;
      logic             opnd_ok;
      sic_simple_kind_e kind;
      logic [31:0]      wdata;
   } sic_ctx_entry_t;

   // Write-back value known at allocation time.
   // LUI places imm16 high; LINK is pc+4 (wraps at 2^32).
   function automatic logic [31:0] sic_wdata(
      input sic_simple_kind_e k,
      input logic [31:0]      pc,
      input logic [15:0]      imm
   );
      logic [31:0] r;
      r = 32'h0;
      if (k == SIC_LUI)  r = {imm, 16'h0};
      if (k == SIC_LINK) r = pc + 32'd4;
      return r;
   endfunction

endpackage

// File: rtl/sic_exec_multi_oldest_pick.sv
// Rotate-from-head priority picker: finds the first set
// request bit at or after head, wrapping mod N (N power of 2).
module sic_oldest_pick #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] head,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] pos;

   // Scan youngest to oldest so the oldest hit is the last write.
   always_comb begin
      found = 1'b0;
      idx   = head;
      pos   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = head + W'(k);
         if (req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/sic_exec_multi.sv
// Multi-context simple SIC executor: circular buffer of packets,
// out-of-order JR operand reads, in-order commit. Option: SIC_EXEC_STATS_EN.
module sic_exec_multi
   import sic_pkg::*;
#(
   parameter  int SIC_ID       = 0,
   parameter  int NUM_CTX      = 4,
   parameter  int NUM_PHY_REGS = 64,
   parameter  int ID_WIDTH     = 8,
   parameter  int NUM_ECR      = 2,
   localparam int PHY_W        = $clog2(NUM_PHY_REGS),
   localparam int ECR_W        = $clog2(NUM_ECR)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  req_instr,
   input  logic                  pkt_valid,
   input  logic [1:0]            pkt_kind,
   input  logic [31:0]           pkt_pc,
   input  logic [15:0]           pkt_imm16,
   input  logic [ID_WIDTH-1:0]   pkt_issue_id,
   input  logic [PHY_W-1:0]      pkt_rs,
   input  logic [PHY_W-1:0]      pkt_dst,
   input  logic [ECR_W-1:0]      pkt_ecr_id,
   output logic                  rd_req,
   output logic [PHY_W-1:0]      rd_addr,
   input  logic                  rd_valid,
   input  logic [31:0]           rd_data,
   input  logic [2*NUM_ECR-1:0]  ecr_status,
   output logic                  wb_valid,
   output logic [PHY_W-1:0]      wb_addr,
   output logic [31:0]           wb_data,
`ifdef SIC_EXEC_STATS_EN
   output logic [31:0]           stat_commits,
   output logic [31:0]           stat_aborts,
   output logic [31:0]           stat_stall_cycles,
`endif
   output logic                  pc_redirect_valid,
   output logic [31:0]           pc_redirect_pc,
   output logic [ID_WIDTH-1:0]   pc_redirect_issue_id
);

   localparam int PTR_W = $clog2(NUM_CTX);
   localparam int CNT_W = PTR_W + 1;

   sic_ctx_entry_t       ent     [NUM_CTX];
   logic [ID_WIDTH-1:0]  ent_id  [NUM_CTX];
   logic [PHY_W-1:0]     ent_rs  [NUM_CTX];
   logic [PHY_W-1:0]     ent_dst [NUM_CTX];
   logic [ECR_W-1:0]     ent_ecr [NUM_CTX];

   logic [1:0]           ent_st  [NUM_CTX];
   logic [NUM_CTX-1:0]   bad;
   logic [NUM_CTX-1:0]   cand;

   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [CNT_W-1:0]     count;
   logic [PTR_W-1:0]     pick;

   sic_ctx_entry_t       hd;
   logic [1:0]           hd_st;
   logic                 silent;
   logic                 commit;
   logic                 retire;
   logic                 accept;
   sic_simple_kind_e     new_kind;

   // Per-entry ECR lookup, abort and operand-pending vectors.
   always_comb begin
      bad  = '0;
      cand = '0;
      for (int i = 0; i < NUM_CTX; i++) begin
         ent_st[i] = ecr_status[{ent_ecr[i], 1'b0} +: 2];
         bad[i]    = ent[i].valid && (ent_st[i] == ECR_BAD);
         cand[i]   = ent[i].valid && !ent[i].dead &&
                     !ent[i].opnd_ok;
      end
   end

   sic_oldest_pick #(
      .N (NUM_CTX)
   ) u_pick (
      .req   (cand),
      .head  (head),
      .found (rd_req),
      .idx   (pick)
   );

   assign rd_addr   = ent_rs[pick];
   assign req_instr = (count != CNT_W'(NUM_CTX));
   assign accept    = pkt_valid && req_instr;
   assign new_kind  = sic_simple_kind_e'(pkt_kind);

   assign hd     = ent[head];
   assign hd_st  = ent_st[head];
   assign silent = hd.valid && (hd.dead || hd_st == ECR_BAD);
   assign commit = hd.valid && !silent && hd.opnd_ok &&
                   (hd_st == ECR_OK);
   assign retire = silent || commit;

   assign wb_valid = commit &&
                     (hd.kind == SIC_LUI || hd.kind == SIC_LINK);
   assign wb_addr  = ent_dst[head];
   assign wb_data  = hd.wdata;

   // Entry storage: abort marking, operand capture, retire, allocate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            ent[i]     <= '0;
            ent_id[i]  <= '0;
            ent_rs[i]  <= '0;
            ent_dst[i] <= '0;
            ent_ecr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CTX; i++) begin
            if (bad[i]) ent[i].dead <= 1'b1;
         end
         if (rd_req && rd_valid) begin
            ent[pick].wdata   <= rd_data;
            ent[pick].opnd_ok <= 1'b1;
         end
         if (retire) ent[head].valid <= 1'b0;
         if (accept) begin
            ent[tail].valid   <= 1'b1;
            ent[tail].dead    <= 1'b0;
            ent[tail].opnd_ok <= (new_kind != SIC_JR);
            ent[tail].kind    <= new_kind;
            ent[tail].wdata   <= sic_wdata(new_kind, pkt_pc,
                                           pkt_imm16);
            ent_id[tail]      <= pkt_issue_id;
            ent_rs[tail]      <= pkt_rs;
            ent_dst[tail]     <= pkt_dst;
            ent_ecr[tail]     <= pkt_ecr_id;
         end
      end
   end

   // Ring pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (retire) head <= head + PTR_W'(1);
         if (accept) tail <= tail + PTR_W'(1);
         count <= count + CNT_W'(accept) - CNT_W'(retire);
      end
   end

   // One-cycle redirect pulse after a JR commits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_redirect_valid    <= 1'b0;
         pc_redirect_pc       <= '0;
         pc_redirect_issue_id <= '0;
      end else begin
         pc_redirect_valid <= 1'b0;
         if (commit && hd.kind == SIC_JR) begin
            pc_redirect_valid    <= 1'b1;
            pc_redirect_pc       <= hd.wdata;
            pc_redirect_issue_id <= ent_id[head];
         end
      end
   end

`ifdef SIC_EXEC_STATS_EN
   // Saturating commit / abort / stall counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_commits      <= '0;
         stat_aborts       <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (commit && stat_commits != '1)
            stat_commits <= stat_commits + 32'd1;
         if (silent && stat_aborts != '1)
            stat_aborts <= stat_aborts + 32'd1;
         if (hd.valid && !retire && stat_stall_cycles != '1)
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end

`ifndef SYNTHESIS
   final begin
      $display("sic_exec_multi[%0d] commits=%0d aborts=%0d stalls=%0d",
               SIC_ID, stat_commits, stat_aborts,
               stat_stall_cycles);
   end
`endif
`endif

endmodule

// File: tb/tb_sic_exec_multi.sv
// Randomized + directed bench for sic_exec_multi.
// Queue-based reference model checked every cycle.
module tb_sic_exec_multi;
   import sic_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_instr;
   logic        pkt_valid;
   logic [1:0]  pkt_kind;
   logic [31:0] pkt_pc;
   logic [15:0] pkt_imm16;
   logic [7:0]  pkt_issue_id;
   logic [5:0]  pkt_rs;
   logic [5:0]  pkt_dst;
   logic [0:0]  pkt_ecr_id;
   logic        rd_req;
   logic [5:0]  rd_addr;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic [3:0]  ecr_status;
   logic        wb_valid;
   logic [5:0]  wb_addr;
   logic [31:0] wb_data;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_pc;
   logic [7:0]  pc_redirect_issue_id;
`ifdef SIC_EXEC_STATS_EN
   logic [31:0] stat_commits;
   logic [31:0] stat_aborts;
   logic [31:0] stat_stall_cycles;
`endif

   sic_exec_multi dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_instr            (req_instr),
      .pkt_valid            (pkt_valid),
      .pkt_kind             (pkt_kind),
      .pkt_pc               (pkt_pc),
      .pkt_imm16            (pkt_imm16),
      .pkt_issue_id         (pkt_issue_id),
      .pkt_rs               (pkt_rs),
      .pkt_dst              (pkt_dst),
      .pkt_ecr_id           (pkt_ecr_id),
      .rd_req               (rd_req),
      .rd_addr              (rd_addr),
      .rd_valid             (rd_valid),
      .rd_data              (rd_data),
      .ecr_status           (ecr_status),
      .wb_valid             (wb_valid),
      .wb_addr              (wb_addr),
      .wb_data              (wb_data),
`ifdef SIC_EXEC_STATS_EN
      .stat_commits         (stat_commits),
      .stat_aborts          (stat_aborts),
      .stat_stall_cycles    (stat_stall_cycles),
`endif
      .pc_redirect_valid    (pc_redirect_valid),
      .pc_redirect_pc       (pc_redirect_pc),
      .pc_redirect_issue_id (pc_redirect_issue_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] wd;
      logic [31:0] tgt;
      logic [7:0]  id;
      logic [5:0]  rs;
      logic [5:0]  dst;
      logic        ecr;
      bit          dead;
      bit          ok;
   } m_t;

   m_t          q[$];
   logic        exp_rv;
   logic [31:0] exp_rpc;
   logic [7:0]  exp_rid;

   logic        l_req, l_rd, l_wb, l_rv;
   logic [5:0]  l_rda, l_wba;
   logic [31:0] l_wbd, l_rpc;
   logic [7:0]  l_rid;

   function automatic logic [1:0] st_of(input logic e);
      return e ? ecr_status[3:2] : ecr_status[1:0];
   endfunction

   task automatic model_clear();
      q.delete();
      exp_rv = 1'b0;
   endtask

   // Check this cycle's outputs, then advance the model by one edge.
   task automatic step();
      bit          e_req, e_rd, e_wb, ret, com;
      logic [5:0]  e_rda, e_wba;
      logic [31:0] e_wbd;
      int          ridx;
      m_t          n;
      #1;
      e_req = (q.size() < 4);
      e_rd  = 0; e_rda = '0; ridx = -1;
      foreach (q[i]) begin
         if (ridx < 0 && !q[i].dead && !q[i].ok) begin
            e_rd = 1; e_rda = q[i].rs; ridx = i;
         end
      end
      e_wb = 0; e_wba = '0; e_wbd = '0; ret = 0; com = 0;
      if (q.size() > 0) begin
         if (q[0].dead || st_of(q[0].ecr) == 2'b10) ret = 1;
         else if (q[0].ok && st_of(q[0].ecr) == 2'b01) begin
            ret = 1; com = 1;
            if (q[0].kind == 2'd1 || q[0].kind == 2'd2) begin
               e_wb = 1; e_wba = q[0].dst; e_wbd = q[0].wd;
            end
         end
      end
      chk("req_instr", {31'b0, req_instr}, {31'b0, e_req});
      chk("rd_req", {31'b0, rd_req}, {31'b0, e_rd});
      if (e_rd) chk("rd_addr", {26'b0, rd_addr}, {26'b0, e_rda});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_wb});
      if (e_wb) begin
         chk("wb_addr", {26'b0, wb_addr}, {26'b0, e_wba});
         chk("wb_data", wb_data, e_wbd);
      end
      chk("redir_valid", {31'b0, pc_redirect_valid}, {31'b0, exp_rv});
      if (exp_rv) begin
         chk("redir_pc", pc_redirect_pc, exp_rpc);
         chk("redir_id", {24'b0, pc_redirect_issue_id}, {24'b0, exp_rid});
      end
      l_req = req_instr; l_rd = rd_req; l_rda = rd_addr;
      l_wb = wb_valid; l_wba = wb_addr; l_wbd = wb_data;
      l_rv = pc_redirect_valid; l_rpc = pc_redirect_pc;
      l_rid = pc_redirect_issue_id;
      foreach (q[i]) if (st_of(q[i].ecr) == 2'b10) q[i].dead = 1;
      if (ridx >= 0 && rd_valid) begin
         q[ridx].ok = 1; q[ridx].tgt = rd_data;
      end
      exp_rv = 1'b0;
      if (ret) begin
         if (com && q[0].kind == 2'd3) begin
            exp_rv = 1'b1; exp_rpc = q[0].tgt; exp_rid = q[0].id;
         end
         void'(q.pop_front());
      end
      if (pkt_valid && e_req) begin
         n.kind = pkt_kind; n.id = pkt_issue_id; n.rs = pkt_rs;
         n.dst = pkt_dst; n.ecr = pkt_ecr_id[0]; n.dead = 0;
         n.ok = (pkt_kind != 2'd3); n.tgt = '0;
         n.wd = (pkt_kind == 2'd1) ? {pkt_imm16, 16'h0} :
                (pkt_kind == 2'd2) ? pkt_pc + 32'd4 : 32'h0;
         q.push_back(n);
      end
      @(negedge clk);
   endtask

   task automatic push(input logic [1:0] k, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [7:0] id,
                       input logic [5:0] rs, input logic [5:0] dst,
                       input logic e);
      pkt_valid = 1; pkt_kind = k; pkt_pc = pc; pkt_imm16 = imm;
      pkt_issue_id = id; pkt_rs = rs; pkt_dst = dst; pkt_ecr_id = e;
      step();
      pkt_valid = 0;
   endtask

   task automatic idle(input int n);
      pkt_valid = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 0; pkt_valid = 0; rd_valid = 0;
      #1;
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_redir_valid", {31'b0, pc_redirect_valid}, 32'd0);
      chk("rst_rd_req", {31'b0, rd_req}, 32'd0);
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   function automatic logic [1:0] rnd_ecr();
      int r;
      r = $urandom_range(0, 19);
      if (r < 13) return 2'b01;
      if (r < 19) return 2'b00;
      return 2'b10;
   endfunction

   int nwb;

   initial begin
      rst_n = 0; pkt_valid = 0; pkt_kind = 0; pkt_pc = 0;
      pkt_imm16 = 0; pkt_issue_id = 0; pkt_rs = 0; pkt_dst = 0;
      pkt_ecr_id = 0; rd_valid = 0; rd_data = 0; ecr_status = 0;
      model_clear();
      #1;
      chk("rst_req_instr", {31'b0, req_instr}, 32'd1);
      chk("rst_redir_pc", pc_redirect_pc, 32'd0);
      chk("rst_redir_id", {24'b0, pc_redirect_issue_id}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      // LUI held by a busy ECR, then released
      ecr_status = 4'b0000;
      push(2'd1, 32'h0, 16'h1234, 8'h01, 6'd0, 6'd5, 1'b0);
      nwb = 0;
      for (int i = 0; i < 3; i++) begin step(); nwb += int'(l_wb); end
      chk("lui_busy_wb", nwb, 0);
      ecr_status = 4'b0101;
      step();
      chk("lui_wb_valid", {31'b0, l_wb}, 32'd1);
      chk("lui_wb_addr", {26'b0, l_wba}, 32'd5);
      chk("lui_wb_data", l_wbd, 32'h1234_0000);
      idle(1);
      chk("lui_wb_once", {31'b0, l_wb}, 32'd0);

      // LINK then JR, in order
      push(2'd2, 32'h0040_0010, 16'h0, 8'h10, 6'd0, 6'd3, 1'b0);
      push(2'd3, 32'h0040_0014, 16'h0, 8'h42, 6'd7, 6'd0, 1'b0);
      chk("link_wb_data", l_wbd, 32'h0040_0014);
      rd_valid = 1; rd_data = 32'h0040_0100;
      step();
      chk("jr_rd_req", {31'b0, l_rd}, 32'd1);
      chk("jr_rd_addr", {26'b0, l_rda}, 32'd7);
      rd_valid = 0;
      step();
      chk("jr_no_wb", {31'b0, l_wb}, 32'd0);
      step();
      chk("jr_redir_valid", {31'b0, l_rv}, 32'd1);
      chk("jr_redir_pc", l_rpc, 32'h0040_0100);
      chk("jr_redir_id", {24'b0, l_rid}, 32'h42);
      step();
      chk("jr_redir_pulse", {31'b0, l_rv}, 32'd0);

      // Fill to full behind a busy head, then wrap
      do_reset();
      ecr_status = 4'b0000;
      for (int i = 0; i < 4; i++)
         push(2'd1, 32'h0, 16'(i + 16'h100), 8'(i), 6'd0, 6'(10 + i), 1'b0);
      pkt_valid = 1; pkt_kind = 2'd1; pkt_imm16 = 16'h0AAA; pkt_dst = 6'd20;
      step();
      chk("full_req_low", {31'b0, l_req}, 32'd0);
      ecr_status = 4'b0101;
      step();
      chk("full_retire_req", {31'b0, l_req}, 32'd0);
      chk("full_retire_wb", {31'b0, l_wb}, 32'd1);
      step();
      chk("full_req_back", {31'b0, l_req}, 32'd1);
      idle(6);

      // Younger entries aborted behind a busy head
      do_reset();
      ecr_status = 4'b0000;
      push(2'd1, 32'h0, 16'h0001, 8'h1, 6'd0, 6'd1, 1'b0);
      push(2'd1, 32'h0, 16'h0002, 8'h2, 6'd0, 6'd2, 1'b1);
      push(2'd2, 32'h10, 16'h0, 8'h3, 6'd0, 6'd3, 1'b1);
      push(2'd3, 32'h20, 16'h0, 8'h4, 6'd4, 6'd0, 1'b1);
      ecr_status = 4'b1000;
      step();
      ecr_status = 4'b0001;
      nwb = 0;
      for (int i = 0; i < 5; i++) begin
         step(); nwb += int'(l_wb) + int'(l_rv);
      end
      chk("abort_outputs", nwb, 1);

      // JR operand stall blocks a ready younger LUI
      do_reset();
      ecr_status = 4'b0101;
      push(2'd3, 32'h0, 16'h0, 8'h77, 6'd9, 6'd0, 1'b0);
      push(2'd1, 32'h0, 16'hBEEF, 8'h78, 6'd0, 6'd8, 1'b0);
      nwb = 0;
      for (int i = 0; i < 5; i++) begin step(); nwb += int'(l_wb); end
      chk("jr_stall_wb", nwb, 0);
      rd_valid = 1; rd_data = 32'h0000_1000;
      step();
      rd_valid = 0;
      step();
      chk("jr_first_no_wb", {31'b0, l_wb}, 32'd0);
      step();
      chk("jr2_redir_valid", {31'b0, l_rv}, 32'd1);
      chk("jr2_redir_pc", l_rpc, 32'h0000_1000);
      chk("jr2_redir_id", {24'b0, l_rid}, 32'h77);
      chk("lui_after_jr_wb", {31'b0, l_wb}, 32'd1);
      chk("lui_after_jr_data", l_wbd, 32'hBEEF_0000);

      // Reset with three pending entries
      ecr_status = 4'b0000;
      for (int i = 0; i < 3; i++)
         push(2'd1, 32'h0, 16'h5555, 8'(i), 6'd0, 6'(i), 1'b0);
      do_reset();
      ecr_status = 4'b0101;
      step();
      chk("post_rst_req", {31'b0, l_req}, 32'd1);
      chk("post_rst_no_wb", {31'b0, l_wb}, 32'd0);
      idle(3);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         pkt_valid    = ($urandom_range(0, 9) < 6);
         pkt_kind     = 2'($urandom_range(0, 3));
         pkt_pc       = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                      : ($urandom & ~32'h3);
         pkt_imm16    = 16'($urandom);
         pkt_issue_id = 8'($urandom);
         pkt_rs       = 6'($urandom);
         pkt_dst      = 6'($urandom);
         pkt_ecr_id   = 1'($urandom);
         rd_valid     = ($urandom_range(0, 1) == 1);
         rd_data      = $urandom;
         ecr_status   = {rnd_ecr(), rnd_ecr()};
         step();
      end
      pkt_valid = 0;
      rd_valid  = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
